// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer, synchronous flush,
// optional zeroing of empty payload, occupancy output and saturating stall counter.
module pipe_stage_skid #(
  parameter int unsigned WIDTH         = 32,
  parameter bit          ZERO_ON_EMPTY = 1'b1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             flush_i,
  output logic [1:0]       count_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  input  logic             cnt_clr_i
);

  logic             r_main_v;
  logic             r_skid_v;
  logic [WIDTH-1:0] r_main_d;
  logic [WIDTH-1:0] r_skid_d;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_accept;
  logic             w_drain;
  logic             w_stall;
  logic             w_stall_sat;
  logic             w_main_v_nxt;
  logic             w_skid_v_nxt;
  logic [WIDTH-1:0] w_main_d_nxt;
  logic [WIDTH-1:0] w_skid_d_nxt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;

  // in_ready_o depends only on state, so out_ready_i never reaches it combinationally.
  assign in_ready_o  = ~r_skid_v;
  assign out_valid_o = r_main_v;
  assign out_data_o  = r_main_d;
  assign count_o     = {r_main_v & r_skid_v, r_main_v ^ r_skid_v};
  assign stall_cnt_o = r_stall_cnt;

  assign w_accept    = in_valid_i & in_ready_o;
  assign w_drain     = out_valid_o & out_ready_i;
  assign w_stall     = out_valid_o & ~out_ready_i;
  assign w_stall_sat = &r_stall_cnt;

  always_comb begin
    w_main_v_nxt = r_main_v;
    w_skid_v_nxt = r_skid_v;
    w_main_d_nxt = r_main_d;
    w_skid_d_nxt = r_skid_d;
    if (flush_i) begin
      w_main_v_nxt = 1'b0;
      w_skid_v_nxt = 1'b0;
      if (ZERO_ON_EMPTY) begin
        w_main_d_nxt = '0;
        w_skid_d_nxt = '0;
      end
    end else begin
      unique case ({r_main_v, r_skid_v})
        2'b00: begin
          if (w_accept) begin
            w_main_v_nxt = 1'b1;
            w_main_d_nxt = in_data_i;
          end
        end
        2'b10: begin
          if (w_accept && w_drain) begin
            w_main_d_nxt = in_data_i;
          end else if (w_accept) begin
            w_skid_v_nxt = 1'b1;
            w_skid_d_nxt = in_data_i;
          end else if (w_drain) begin
            w_main_v_nxt = 1'b0;
            if (ZERO_ON_EMPTY) begin
              w_main_d_nxt = '0;
            end
          end
        end
        2'b11: begin
          if (w_drain) begin
            w_main_d_nxt = r_skid_d;
            w_skid_v_nxt = 1'b0;
            if (ZERO_ON_EMPTY) begin
              w_skid_d_nxt = '0;
            end
          end
        end
        default: begin
          // Unreachable skid-only state; fall back to empty rather than emit a hole.
          w_main_v_nxt = 1'b0;
          w_skid_v_nxt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_stall_cnt_nxt = r_stall_cnt;
    if (cnt_clr_i) begin
      w_stall_cnt_nxt = '0;
    end else if (w_stall && !w_stall_sat) begin
      w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_main_v    <= 1'b0;
      r_skid_v    <= 1'b0;
      r_main_d    <= '0;
      r_skid_d    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_main_v    <= w_main_v_nxt;
      r_skid_v    <= w_skid_v_nxt;
      r_main_d    <= w_main_d_nxt;
      r_skid_d    <= w_skid_d_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

endmodule
